// File: rtl/expr_pkg.sv
// Shared encodings for the expression evaluator: FSM states, character
// constants and the decoded-character bundle used by the syntax checker.
package expr_pkg;

  localparam logic [1:0] S0   = 2'd0;
  localparam logic [1:0] SD   = 2'd1;
  localparam logic [1:0] SOP  = 2'd2;
  localparam logic [1:0] SERR = 2'd3;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_EQ  = 8'h3D;

  localparam int unsigned DIG_W = 4;
  localparam int unsigned ACC_W = 32;

  typedef struct packed {
    logic             is_digit;
    logic             is_add;
    logic             is_mul;
    logic             is_eq;
    logic             is_bad;
    logic [DIG_W-1:0] digit_val;
  } char_class_t;

endpackage

// File: rtl/expr_char_class.sv
// Combinational decode of one ASCII character into its token class.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]       in,
  output logic             is_digit,
  output logic             is_add,
  output logic             is_mul,
  output logic             is_eq,
  output logic             is_bad,
  output logic [DIG_W-1:0] digit_val
);

  logic [7:0] off;

  always_comb begin
    off       = in - CH_0;
    is_digit  = (in >= CH_0) && (in <= CH_9);
    is_add    = (in == CH_ADD);
    is_mul    = (in == CH_MUL);
    is_eq     = (in == CH_EQ);
    is_bad    = !(is_digit || is_add || is_mul || is_eq);
    digit_val = is_digit ? off[DIG_W-1:0] : '0;
  end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for "digit (op digit)* =" with '*' binding tighter
// than '+'; sum holds finished terms, prod the term being built.
module expr_eval
  import expr_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             done,
  output logic             ok,
  output logic [ACC_W-1:0] result
);

  char_class_t cc;

  expr_char_class u_cls (
    .in        (in),
    .is_digit  (cc.is_digit),
    .is_add    (cc.is_add),
    .is_mul    (cc.is_mul),
    .is_eq     (cc.is_eq),
    .is_bad    (cc.is_bad),
    .digit_val (cc.digit_val)
  );

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic             mul_pending_q, mul_pending_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;

  // Single-cycle 32x4 multiply: one shifted partial product per digit bit.
  logic [DIG_W-1:0][ACC_W-1:0] pp;
  logic [ACC_W-1:0]            prod_x;

  for (genvar g = 0; g < DIG_W; g++) begin : g_pp
    assign pp[g] = cc.digit_val[g] ? (prod_q << g) : '0;
  end

  assign prod_x = pp[0] + pp[1] + pp[2] + pp[3];

  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    prod_d        = prod_q;
    mul_pending_d = mul_pending_q;
    result_d      = result_q;
    done_d        = 1'b0;
    ok_d          = 1'b0;

    if (in_valid) begin
      case (state_q)
        S0, SOP: begin
          if (cc.is_digit) begin
            prod_d  = mul_pending_q ? prod_x : {{(ACC_W-DIG_W){1'b0}}, cc.digit_val};
            state_d = SD;
          end else if (cc.is_eq) begin
            done_d  = 1'b1;
            state_d = S0;
          end else begin
            state_d = SERR;
          end
        end
        SD: begin
          if (cc.is_add) begin
            sum_d         = sum_q + prod_q;
            mul_pending_d = 1'b0;
            state_d       = SOP;
          end else if (cc.is_mul) begin
            mul_pending_d = 1'b1;
            state_d       = SOP;
          end else if (cc.is_eq) begin
            result_d = sum_q + prod_q;
            done_d   = 1'b1;
            ok_d     = 1'b1;
            state_d  = S0;
          end else begin
            state_d = SERR;
          end
        end
        default: begin
          if (cc.is_eq) begin
            done_d  = 1'b1;
            state_d = S0;
          end
        end
      endcase

      // Every termination starts the next expression from a clean slate.
      if (cc.is_eq) begin
        sum_d         = '0;
        prod_d        = '0;
        mul_pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= S0;
      sum_q         <= '0;
      prod_q        <= '0;
      mul_pending_q <= 1'b0;
      result_q      <= '0;
      done_q        <= 1'b0;
      ok_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      prod_q        <= prod_d;
      mul_pending_q <= mul_pending_d;
      result_q      <= result_d;
      done_q        <= done_d;
      ok_q          <= ok_d;
    end
  end

  assign done   = done_q;
  assign ok     = ok_q;
  assign result = result_q;

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: a string-level model evaluates each
// expression on '=' and queues the expected termination for the monitor.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ch = 8'h00;
  logic        done;
  logic        ok;
  logic [31:0] result;

  expr_eval dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in       (in_ch),
    .done     (done),
    .ok       (ok),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          okv;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  byte unsigned buf_q[$];
  logic [31:0] model_res = 32'd0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_dig(byte unsigned c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Grammar check by position, then sum-of-products evaluation.
  task automatic model_eval(output bit okv, output logic [31:0] v);
    int unsigned sum, term, n;
    n   = buf_q.size();
    okv = (n % 2) == 1;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) okv = okv && is_dig(buf_q[i]);
      else            okv = okv && (buf_q[i] == "+" || buf_q[i] == "*");
    end
    v = 32'd0;
    if (okv) begin
      sum  = 0;
      term = buf_q[0] - 8'h30;
      for (int i = 1; i < n; i += 2) begin
        if (buf_q[i] == "*") term = term * (buf_q[i+1] - 8'h30);
        else begin
          sum  = sum + term;
          term = buf_q[i+1] - 8'h30;
        end
      end
      v = sum + term;
    end
  endtask

  task automatic send(byte unsigned c);
    bit          okv;
    logic [31:0] v;
    in_valid = 1'b1;
    in_ch    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_ch    = 8'($urandom);
    if (c == "=") begin
      model_eval(okv, v);
      if (okv) model_res = v;
      exp_q.push_back('{okv, model_res, cyc});
      buf_q.delete();
    end else begin
      buf_q.push_back(c);
    end
  endtask

  // Idle cycles carry random characters, including '=', that must be ignored.
  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      in_ch = ($urandom_range(0, 3) == 0) ? 8'h3D : 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_str(string s, int gap_max);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (done) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, none expected", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (ok !== e.okv || result !== e.res || cyc != e.cyc) begin
            fails++;
            $display("FAIL done_check: ok=%0b result=%0d cycle=%0d, expected ok=%0b result=%0d cycle=%0d",
                     ok, result, cyc, e.okv, e.res, e.cyc);
          end
        end
      end else if (ok) begin
        tests++;
        fails++;
        $display("FAIL ok_without_done: ok=1 done=0 at cycle %0d", cyc);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_ok", {31'd0, ok}, 32'd0);
    check("reset_result", result, 32'd0);
    clr = 1'b0;

    send_str("1+2*3=", 0);
    idle(2);
    check("held_7", result, 32'd7);

    send_str("2*3*4+5=", 0);
    send_str("8=", 0);
    idle(1);
    send_str("12=", 0);
    send_str("+1=", 0);
    send_str("3+=", 0);
    send_str("4#5=", 0);
    idle(2);
    check("held_after_errors", result, 32'd8);

    send_str("9", 0);
    for (int i = 0; i < 10; i++) send_str("*9", 0);
    send_str("=", 0);
    idle(2);
    check("pow9_11", result, 32'd1316288537);

    // Abandon a partial expression with an asynchronous pulse between edges.
    send_str("3*", 0);
    clr = 1'b1;
    #2;
    check("midclr_done", {31'd0, done}, 32'd0);
    check("midclr_result", result, 32'd0);
    #1;
    clr = 1'b0;
    buf_q.delete();
    model_res = 32'd0;
    send_str("4=", 0);
    idle(2);
    check("after_clr", result, 32'd4);

    send_str("5+6=", 4);
    idle(2);
    check("gapped_11", result, 32'd11);

    for (int k = 0; k < 60; k++) begin
      int           nd;
      byte unsigned e[$];
      nd = $urandom_range(1, 5);
      for (int i = 0; i < nd; i++) begin
        if (i > 0) e.push_back(($urandom_range(0, 1) == 0) ? "+" : "*");
        e.push_back(8'h30 + 8'($urandom_range(0, 9)));
      end
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0: e[$urandom_range(0, e.size()-1)] = "#";
          1: e[$urandom_range(0, e.size()-1)] = "+";
          2: e[$urandom_range(0, e.size()-1)] = 8'h30 + 8'($urandom_range(0, 9));
          default: e[$urandom_range(0, e.size()-1)] = 8'($urandom);
        endcase
      end
      e.push_back("=");
      foreach (e[i]) begin
        send(e[i]);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end

    idle(4);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_result", result, model_res);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/expr_eval.md
EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have clr, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have in_valid, input, 1, qualifies in; when low, the cycle is ignored.
REQ-004 SHALL have in, input, 8, ASCII character: '0'-'9', '+', '*', '=', anything else.
REQ-005 SHALL have done, output, 1, one-cycle pulse when an expression terminates.
REQ-006 SHALL have ok, output, 1, valid with done: 1 = well-formed, 0 = syntax error.
REQ-007 SHALL have result, output, 32, value of the last well-formed expression; held until the next ok termination.

Function
REQ-008 SHALL evaluate expressions of the form digit (op digit)* '=', with single-digit operands only and op in {'+', '*'}.
REQ-009 SHALL give '*' precedence over '+', with left-to-right evaluation; all arithmetic is unsigned modulo 2^32.
REQ-010 SHALL use states S0 (expecting first digit), SD (digit just seen), SOP (operator just seen) and SERR (error, draining).
REQ-011 SHALL keep two 32-bit registers, sum and prod, plus a 1-bit mul_pending flag.
REQ-012 SHALL handle a digit d in S0/SOP as follows: prod <= mul_pending ? prod*d : d; go to SD.
REQ-013 SHALL handle '+' in SD as follows: sum <= sum+prod, mul_pending <= 0; go to SOP.
REQ-014 SHALL handle '*' in SD as follows: mul_pending <= 1, sum unchanged; go to SOP.
REQ-015 SHALL handle '=' in SD as follows: result <= sum+prod, done=1, ok=1 on the next cycle; sum, prod and mul_pending cleared; go to S0.
REQ-016 SHALL handle '=' in S0, SOP or SERR as follows: done=1, ok=0, result unchanged; registers cleared; go to S0.
REQ-017 SHALL go to SERR on any of these: digit in SD, operator in S0/SOP, or an illegal character in any non-SERR state.
REQ-018 SHALL, in SERR, ignore every character except '='.
REQ-019 SHALL register done and ok one cycle after the accepted '=' character; both are 0 in all other cycles.
REQ-020 SHALL let back-to-back expressions run with no idle cycle: the character after '=' is processed as the first character of a new expression.
REQ-021 SHALL leave state and registers unchanged in any cycle where in_valid=0.

Reset
REQ-022 SHALL, on clr=1 (asynchronous), force state=S0; sum=prod=0; mul_pending=0; result=0; done=0; ok=0.
REQ-023 SHALL discard any partial expression when clr is asserted mid-expression, with no done pulse.
REQ-024 SHALL process the first character on the first rising edge after clr deasserts.

Structure
REQ-025 SHALL place the state encoding (S0, SD, SOP, SERR) and the character constants ('0', '9', '+', '*', '=') in a shared package expr_pkg, which also serves the syntax checker.
REQ-026 SHALL use one combinational sub-module, expr_char_class, which decodes in into is_digit, is_add, is_mul, is_eq, is_bad and digit_val[3:0].
REQ-027 SHALL implement the multiply as a 32x4 product, with no multi-cycle multiplier.

Verification
REQ-028 SHALL cover: "1+2*3=" -> done, ok=1, result=7, asserted 1 cycle after '='.
REQ-029 SHALL cover: "2*3*4+5=" then immediately "8=" -> first result=29, next result=8, with consecutive done pulses.
REQ-030 SHALL cover: "12=", "+1=", "3+=", "4#5=" -> each gives done, ok=0, and result still holds the prior value.
REQ-031 SHALL cover: '9' followed by ten repetitions of "*9", then "=" -> ok=1, result=1316288537 (9^11 mod 2^32).
REQ-032 SHALL cover: "3*", then clr pulsed between edges, then "4=" -> no done during reset, then result=4, ok=1.
REQ-033 SHALL cover: "5+6=" with in_valid=0 gaps of random length between characters -> result=11, with no extra done pulses.
